// File: rtl/pe_array_tiled_pkg.sv
// Shared types and width helpers for the tiled PE array.
package pe_array_tiled_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

    // Signed PE product width: activation shifted by up to 2^(W-1)-1, plus sign.
    function automatic int pe_out_width(int act_w, int w_w);
        return act_w + (2 ** w_w) / 2;
    endfunction

    function automatic int tree_width(int act_w, int w_w, int rows);
        return pe_out_width(act_w, w_w) + $clog2(rows);
    endfunction

    // Clamp a signed value into a w-bit signed range (w <= 63).
    function automatic logic signed [63:0] saturate(logic signed [63:0] x, int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/pe.sv
// Weight-applying PE cell. Code 0 is a zero weight; otherwise the MSB is the
// sign and the remaining bits are a power-of-two exponent applied to the input.
module pe #(
    parameter int ACT_W = 4,
    parameter int W_W   = 4,
    parameter int OUT_W = 12
) (
    input  logic [ACT_W-1:0]        act_i,
    input  logic [W_W-1:0]          w_i,
    output logic signed [OUT_W-1:0] prod_o
);
    logic [OUT_W-1:0] mag;

    // product = +/- act << exponent
    always_comb begin
        mag = OUT_W'(act_i) << w_i[W_W-2:0];
        if (w_i == '0)        prod_o = '0;
        else if (w_i[W_W-1])  prod_o = -$signed(mag);
        else                  prod_o = $signed(mag);
    end
endmodule

// File: rtl/pe_array_tiled_col.sv
// Per-column processor: adder tree over row-gated PE products, scaled
// saturating accumulation, and ReLU/shift/clamp requantization.
module pe_col_processor
    import pe_array_tiled_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int ACT_W   = 4,
    parameter int PE_W    = 12,
    parameter int TREE_W  = 16,
    parameter int BIAS_W  = 20,
    parameter int SCALE_W = 4,
    parameter int ACC_W   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROWS-1:0][PE_W-1:0]  pe_i,
    input  logic [ACT_W-1:0]           ident_i,
    input  logic                       identity_i,
    input  logic                       active_i,
    input  logic                       acc_en_i,
    input  logic                       first_i,
    input  logic                       load_out_i,
    input  logic [BIAS_W-1:0]          bias_i,
    input  logic [SCALE_W-1:0]         in_scale_i,
    input  logic [SCALE_W-1:0]         out_scale_i,
    output logic [ACC_W-1:0]           acc_o,
    output logic [ACT_W-1:0]           out_o
);
    localparam logic [ACT_W-1:0] OUT_MAX = '1;

    logic signed [TREE_W-1:0] tree_sum;
    logic signed [TREE_W-1:0] col_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W:0]    total;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic [ACC_W-1:0]         req_shift;
    logic [ACT_W-1:0]         out_d, out_q;

    // adder tree; gated rows already contribute zero
    always_comb begin
        tree_sum = '0;
        for (int r = 0; r < ROWS; r++)
            tree_sum = tree_sum + TREE_W'($signed(pe_i[r]));
    end

    // scale at accumulator width, add bias on tile 0 else running sum, clamp
    always_comb begin
        col_sum = identity_i ? TREE_W'({1'b0, ident_i}) : tree_sum;
        shifted = ACC_W'(col_sum) <<< in_scale_i;
        base    = first_i ? ACC_W'($signed(bias_i)) : acc_q;
        total   = (ACC_W+1)'(shifted) + (ACC_W+1)'(base);
        acc_d   = ACC_W'(saturate(64'(total), ACC_W));
    end

    // requantize the settled accumulator: ReLU, right shift, clamp
    always_comb begin
        req_shift = acc_q >> out_scale_i;
        out_d     = '0;
        if (active_i && acc_q > 0)
            out_d = (req_shift > ACC_W'(OUT_MAX)) ? OUT_MAX : req_shift[ACT_W-1:0];
    end

    // accumulator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            if (acc_en_i && active_i) acc_q <= acc_d;
            if (load_out_i)           out_q <= out_d;
        end
    end

    assign acc_o = active_i ? acc_q : {1'b1, {(ACC_W-1){1'b0}}};
    assign out_o = out_q;
endmodule

// File: rtl/pe_array_tiled.sv
// Tiled PE array: ROWS x COLS PE grid, per-column accumulators, tile FSM.
// Optional PE_ARRAY_TILED_ARGMAX_EN adds a registered argmax_idx output.
module pe_array_tiled
    import pe_array_tiled_pkg::*;
#(
    parameter int ROWS                   = 16,
    parameter int COLS                   = 16,
    parameter int ACTIVATION_BIT_WIDTH   = 4,
    parameter int WEIGHT_BIT_WIDTH       = 4,
    parameter int BIAS_BIT_WIDTH         = 20,
    parameter int SCALE_BIT_WIDTH        = 4,
    parameter int ACCUMULATION_BIT_WIDTH = 24,
    parameter int TILE_COUNT_BIT_WIDTH   = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [TILE_COUNT_BIT_WIDTH-1:0]                       num_tiles,
    input  logic [$clog2(ROWS+1)-1:0]                             active_rows,
    input  logic [$clog2(COLS+1)-1:0]                             active_cols,
    input  logic                                                  apply_identity,
    input  logic [SCALE_BIT_WIDTH-1:0]                            in_scale,
    input  logic [SCALE_BIT_WIDTH-1:0]                            out_scale,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [ROWS-1:0][ACTIVATION_BIT_WIDTH-1:0]             in,
    input  logic [ROWS-1:0][COLS-1:0][WEIGHT_BIT_WIDTH-1:0]       weights,
    input  logic [COLS-1:0][BIAS_BIT_WIDTH-1:0]                   biases,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [COLS-1:0][ACTIVATION_BIT_WIDTH-1:0]             out,
    output logic [COLS-1:0][ACCUMULATION_BIT_WIDTH-1:0]           col_accumulator,
    output logic                                                  busy
`ifdef PE_ARRAY_TILED_ARGMAX_EN
    ,
    output logic [$clog2(COLS)-1:0]                               argmax_idx
`endif
);
    localparam int PE_W = pe_out_width(ACTIVATION_BIT_WIDTH, WEIGHT_BIT_WIDTH);
    localparam int TR_W = tree_width(ACTIVATION_BIT_WIDTH, WEIGHT_BIT_WIDTH, ROWS);
    localparam int RW   = $clog2(ROWS + 1);
    localparam int CW   = $clog2(COLS + 1);
    localparam int TW   = TILE_COUNT_BIT_WIDTH;

    if (ACCUMULATION_BIT_WIDTH < TR_W) begin : g_acc_w_chk
        $fatal(1, "ACCUMULATION_BIT_WIDTH is narrower than the adder tree");
    end

    state_e                      state_q, state_d;
    logic [TW-1:0]               tile_cnt_q, num_tiles_q, ntiles_eff;
    logic [RW-1:0]               active_rows_q, rows_eff;
    logic [CW-1:0]               active_cols_q, cols_eff;
    logic                        identity_q, out_valid_q;
    logic [SCALE_BIT_WIDTH-1:0]  in_scale_q, out_scale_q;
    logic                        acc_en, load_out, last_tile;

    logic [ROWS-1:0][ACTIVATION_BIT_WIDTH-1:0] in_g;
    logic [COLS-1:0][ACTIVATION_BIT_WIDTH-1:0] ident;
    logic [COLS-1:0][ROWS-1:0][PE_W-1:0]       pe_out;
    logic [COLS-1:0]                           col_act;

    // zero / out-of-range config selects the full extent
    assign ntiles_eff = (num_tiles_q == '0) ? TW'(1) : num_tiles_q;
    assign rows_eff   = (active_rows_q == '0 || active_rows_q > RW'(ROWS)) ? RW'(ROWS) : active_rows_q;
    assign cols_eff   = (active_cols_q == '0 || active_cols_q > CW'(COLS)) ? CW'(COLS) : active_cols_q;
    assign last_tile  = (tile_cnt_q == ntiles_eff - TW'(1));
    assign acc_en     = (state_q == ACCUM) && in_valid;
    assign load_out   = (state_q == OUTPUT) && !out_valid_q;
    assign out_valid  = out_valid_q;

    // gate rows at or above active_rows to zero before the grid
    always_comb begin
        in_g = '0;
        for (int r = 0; r < ROWS; r++)
            if (r < int'(rows_eff)) in_g[r] = in[r];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pe #(.ACT_W(ACTIVATION_BIT_WIDTH), .W_W(WEIGHT_BIT_WIDTH), .OUT_W(PE_W)) u_pe (
                .act_i  (in_g[r]),
                .w_i    (weights[r][c]),
                .prod_o (pe_out[c][r])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cp
        if (c < ROWS) begin : g_id
            assign ident[c] = in_g[c];
        end else begin : g_nid
            assign ident[c] = '0;
        end
        assign col_act[c] = (c < int'(cols_eff));

        pe_col_processor #(
            .ROWS(ROWS), .ACT_W(ACTIVATION_BIT_WIDTH), .PE_W(PE_W), .TREE_W(TR_W),
            .BIAS_W(BIAS_BIT_WIDTH), .SCALE_W(SCALE_BIT_WIDTH), .ACC_W(ACCUMULATION_BIT_WIDTH)
        ) u_col (
            .clk         (clk),
            .rst         (rst),
            .pe_i        (pe_out[c]),
            .ident_i     (ident[c]),
            .identity_i  (identity_q),
            .active_i    (col_act[c]),
            .acc_en_i    (acc_en),
            .first_i     (tile_cnt_q == '0),
            .load_out_i  (load_out),
            .bias_i      (biases[c]),
            .in_scale_i  (in_scale_q),
            .out_scale_i (out_scale_q),
            .acc_o       (col_accumulator[c]),
            .out_o       (out[c])
        );
    end

    // next state and stream-ready outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_tile) state_d = OUTPUT;
            end
            OUTPUT:  if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, config latch, tile counter, output-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tile_cnt_q    <= '0;
            num_tiles_q   <= '0;
            active_rows_q <= '0;
            active_cols_q <= '0;
            identity_q    <= 1'b0;
            in_scale_q    <= '0;
            out_scale_q   <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                num_tiles_q   <= num_tiles;
                active_rows_q <= active_rows;
                active_cols_q <= active_cols;
                identity_q    <= apply_identity;
                in_scale_q    <= in_scale;
                out_scale_q   <= out_scale;
                tile_cnt_q    <= '0;
            end
            if (acc_en) tile_cnt_q <= tile_cnt_q + TW'(1);
            if (load_out)
                out_valid_q <= 1'b1;
            else if (state_q == OUTPUT && out_valid_q && out_ready)
                out_valid_q <= 1'b0;
        end
    end

`ifdef PE_ARRAY_TILED_ARGMAX_EN
    localparam int AW = $clog2(COLS);
    logic [AW-1:0]                       amax_d, amax_q;
    logic signed [ACCUMULATION_BIT_WIDTH-1:0] best;

    // strict greater-than keeps the lowest index on ties; column 0 is always active
    always_comb begin
        amax_d = '0;
        best   = $signed(col_accumulator[0]);
        for (int c = 1; c < COLS; c++)
            if (col_act[c] && $signed(col_accumulator[c]) > best) begin
                best   = $signed(col_accumulator[c]);
                amax_d = AW'(c);
            end
    end

    // argmax registered alongside out
    always_ff @(posedge clk) begin
        if (rst)           amax_q <= '0;
        else if (load_out) amax_q <= amax_d;
    end

    assign argmax_idx = amax_q;
`endif
endmodule
